// File: rtl/hwpf_nl_issuer.sv
// Next-line prefetch issuer. It expands a CPU miss into the following cache lines and drops
// candidates already in hwpf_fifo. It issues survivors one at a time and writes them back.
module hwpf_nl_issuer #(
  parameter int unsigned QUEUE_DEPTH     = 3,
  parameter int unsigned INSERTS         = 2,
  parameter int unsigned LINE_BYTES      = 64,
  parameter int unsigned NUM_LINES       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PAGE_BITS       = 12,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               trig_valid_i,
  input  logic [ADDR_W-1:0]                  trig_addr_i,
  input  logic [QUEUE_DEPTH-1:0][ADDR_W-1:0] fifo_data_cpu_i,
  input  logic [QUEUE_DEPTH-1:0]             fifo_data_valid_i,
  output logic [INSERTS-1:0]                 fifo_take_req_o,
  output logic [INSERTS-1:0][ADDR_W-1:0]     fifo_cpu_req_o,
  output logic                               pf_req_valid_o,
  output logic [ADDR_W-1:0]                  pf_req_addr_o,
  input  logic                               pf_req_ready_i,
  input  logic                               pf_rsp_valid_i,
  output logic                               busy_o
);

  // state | meaning
  // IDLE  | waiting for a miss trigger
  // GEN   | evaluating candidate base + idx*LINE_BYTES, one per cycle
  // ISSUE | presenting a surviving candidate to the memory side
  typedef enum logic [1:0] {IDLE, GEN, ISSUE} state_e;

  localparam int unsigned       LINE_SHIFT = $clog2(LINE_BYTES);
  localparam logic [2:0]        IDX_LAST   = 3'(NUM_LINES);
  localparam logic [3:0]        OUT_MAX    = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] LINE_MASK  = {ADDR_W{1'b1}} << LINE_SHIFT;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cpu_req_q, cpu_req_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        out_q, out_d;
  logic              valid_q, valid_d;
  logic              take_q, take_d;
  logic              busy_q, busy_d;

  logic [ADDR_W:0]   cand_sum;
  logic [ADDR_W-1:0] cand;
  logic              cand_carry, cand_xpage, cand_hit, cand_skip;
  logic              hs, rsp_eff;

  assign cand_sum   = {1'b0, base_q} + ((ADDR_W+1)'(idx_q) << LINE_SHIFT);
  assign cand       = cand_sum[ADDR_W-1:0];
  assign cand_carry = cand_sum[ADDR_W];
  assign cand_xpage = cand[ADDR_W-1:PAGE_BITS] != base_q[ADDR_W-1:PAGE_BITS];
  assign cand_skip  = cand_carry | cand_xpage | cand_hit;

  always_comb begin
    cand_hit = 1'b0;
    for (int j = 0; j < QUEUE_DEPTH; j++) begin
      if (fifo_data_valid_i[j] && (fifo_data_cpu_i[j] == cand)) cand_hit = 1'b1;
    end
  end

  // A response arriving with nothing in flight is stray and must not wrap the counter.
  assign hs      = valid_q & pf_req_ready_i;
  assign rsp_eff = pf_rsp_valid_i & (out_q != 4'd0);

  always_comb begin
    case ({hs, rsp_eff})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    cpu_req_d = cpu_req_q;
    valid_d   = 1'b0;
    take_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig_valid_i) begin
          base_d  = trig_addr_i & LINE_MASK;
          idx_d   = 3'd1;
          state_d = GEN;
        end
      end
      GEN: begin
        if (cand_skip) begin
          if (idx_q == IDX_LAST) state_d = IDLE;
          else                   idx_d   = idx_q + 3'd1;
        end else begin
          addr_d  = cand;
          valid_d = out_d < OUT_MAX;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          take_d    = 1'b1;
          cpu_req_d = addr_q;
          idx_d     = idx_q + 3'd1;
          state_d   = (idx_q == IDX_LAST) ? IDLE : GEN;
        end else begin
          valid_d = out_d < OUT_MAX;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush withdraws the request and suppresses the write-back, but a handshake
    // already taken this cycle still counts as in flight via out_d.
    if (flush_i) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      take_d    = 1'b0;
      cpu_req_d = cpu_req_q;
    end

    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      cpu_req_q <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      take_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      cpu_req_q <= cpu_req_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      take_q    <= take_d;
      busy_q    <= busy_d;
    end
  end

  assign pf_req_valid_o = valid_q;
  assign pf_req_addr_o  = addr_q;
  assign busy_o         = busy_q;

  always_comb begin
    fifo_take_req_o    = '0;
    fifo_cpu_req_o     = '0;
    fifo_take_req_o[0] = take_q;
    fifo_cpu_req_o[0]  = cpu_req_q;
  end

endmodule

// File: tb/tb_hwpf_nl_issuer.sv
// Bench for hwpf_nl_issuer. It runs directed scenarios, then random traffic.
// Both are checked against a queue-based reference model of the prefetch flow.
module tb_hwpf_nl_issuer;
  localparam int QD   = 3;
  localparam int INS  = 2;
  localparam int NL   = 2;
  localparam int MAXO = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  flush_i, trig_valid_i, pf_req_ready_i, pf_rsp_valid_i;
  logic [31:0]           trig_addr_i;
  logic [QD-1:0][31:0]   fifo_data_cpu_i;
  logic [QD-1:0]         fifo_data_valid_i;
  logic [INS-1:0]        fifo_take_req_o;
  logic [INS-1:0][31:0]  fifo_cpu_req_o;
  logic                  pf_req_valid_o, busy_o;
  logic [31:0]           pf_req_addr_o;

  hwpf_nl_issuer #(
    .QUEUE_DEPTH(QD), .INSERTS(INS), .LINE_BYTES(64), .NUM_LINES(NL),
    .MAX_OUTSTANDING(MAXO), .PAGE_BITS(12), .ADDR_W(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .trig_valid_i(trig_valid_i), .trig_addr_i(trig_addr_i),
    .fifo_data_cpu_i(fifo_data_cpu_i), .fifo_data_valid_i(fifo_data_valid_i),
    .fifo_take_req_o(fifo_take_req_o), .fifo_cpu_req_o(fifo_cpu_req_o),
    .pf_req_valid_o(pf_req_valid_o), .pf_req_addr_o(pf_req_addr_o),
    .pf_req_ready_i(pf_req_ready_i), .pf_rsp_valid_i(pf_rsp_valid_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a trigger becomes a list of NUM_LINES candidates (each costing one
  // evaluation cycle), survivors wait for a handshake, and the in-flight count gates valid.
  typedef struct {
    logic [31:0] addr;
    bit          keep;
  } cand_t;

  cand_t       plan[$];
  logic [31:0] seen[$];
  bit          m_req, m_valid, m_take, m_busy;
  logic [31:0] m_addr, m_take_addr;
  int          m_out;

  function automatic bit in_fifo(logic [31:0] a);
    for (int j = 0; j < QD; j++)
      if (fifo_data_valid_i[j] && fifo_data_cpu_i[j] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_plan(logic [31:0] ta);
    logic [31:0] base;
    logic [32:0] c;
    cand_t       e;
    base = ta & 32'hFFFF_FFC0;
    for (int k = 1; k <= NL; k++) begin
      c      = {1'b0, base} + 33'(k * 64);
      e.addr = c[31:0];
      e.keep = !c[32] && (c[31:12] == base[31:12]) && !in_fifo(c[31:0]);
      plan.push_back(e);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_req = 0; m_valid = 0; m_take = 0; m_busy = 0; m_out = 0;
    m_addr = '0; m_take_addr = '0;
  endtask

  task automatic model_step();
    bit    hs;
    int    nxt;
    cand_t c;
    hs  = m_valid && pf_req_ready_i;
    nxt = m_out + (hs ? 1 : 0) - ((pf_rsp_valid_i && m_out > 0) ? 1 : 0);
    m_take = 0;
    if (flush_i) begin
      plan.delete();
      m_req = 0; m_valid = 0;
    end else if (m_req) begin
      if (hs) begin
        m_take = 1; m_take_addr = m_addr; m_req = 0; m_valid = 0;
      end else begin
        m_valid = nxt < MAXO;
      end
    end else if (plan.size() > 0) begin
      c = plan.pop_front();
      if (c.keep) begin
        m_req = 1; m_addr = c.addr; m_valid = nxt < MAXO;
      end
    end else if (trig_valid_i) begin
      build_plan(trig_addr_i);
    end
    m_out  = nxt;
    m_busy = m_req || plan.size() > 0;
  endtask

  task automatic compare();
    check_eq("valid", pf_req_valid_o, m_valid);
    if (m_req) check_eq("addr", pf_req_addr_o, m_addr);
    check_eq("take", fifo_take_req_o, {1'b0, m_take});
    if (m_take) check_eq("cpu_req", fifo_cpu_req_o[0], m_take_addr);
    check_eq("cpu_req1", fifo_cpu_req_o[1], 0);
    check_eq("busy", busy_o, m_busy);
    if (fifo_take_req_o[0]) seen.push_back(fifo_cpu_req_o[0]);
  endtask

  task automatic cycle(bit trig, logic [31:0] ta, bit fl, bit rdy, bit rsp);
    trig_valid_i   = trig;
    trig_addr_i    = ta;
    flush_i        = fl;
    pf_req_ready_i = rdy;
    pf_rsp_valid_i = rsp;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare();
  endtask

  task automatic run_idle(string tag, bit rdy, int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      cycle(0, '0, 0, rdy, 0);
      n++;
    end
    check_eq(tag, busy_o, 0);
  endtask

  task automatic drain();
    repeat (6) cycle(0, '0, 0, 0, 1);
  endtask

  function automatic logic [31:0] seen_at(int i);
    return (i < seen.size()) ? seen[i] : 32'h0;
  endfunction

  logic [31:0] region;

  initial begin
    rst_ni = 1'b0;
    flush_i = 0; trig_valid_i = 0; trig_addr_i = '0;
    pf_req_ready_i = 0; pf_rsp_valid_i = 0;
    fifo_data_cpu_i = '0; fifo_data_valid_i = '0;
    model_reset();
    #3;
    check_eq("rst_valid", pf_req_valid_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_take", fifo_take_req_o, 0);
    check_eq("rst_addr", pf_req_addr_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Plain trigger, empty FIFO: two requests, first valid two cycles after the trigger
    seen.delete();
    cycle(1, 32'hCAFE0010, 0, 1, 0);
    check_eq("d1_gen_valid", pf_req_valid_o, 0);
    cycle(0, '0, 0, 1, 0);
    check_eq("d1_lat_valid", pf_req_valid_o, 1);
    check_eq("d1_lat_addr", pf_req_addr_o, 32'hCAFE0040);
    run_idle("d1_idle", 1, 20);
    check_eq("d1_count", seen.size(), 2);
    check_eq("d1_req0", seen_at(0), 32'hCAFE0040);
    check_eq("d1_req1", seen_at(1), 32'hCAFE0080);
    drain();

    // Valid FIFO entry filters, invalid one does not
    fifo_data_cpu_i[0] = 32'hCAFE0040; fifo_data_cpu_i[1] = 32'hCAFE0080;
    fifo_data_valid_i = 3'b001;
    seen.delete();
    cycle(1, 32'hCAFE0000, 0, 1, 0);
    run_idle("d2_idle", 1, 20);
    check_eq("d2_count", seen.size(), 1);
    check_eq("d2_req0", seen_at(0), 32'hCAFE0080);
    drain();
    fifo_data_valid_i = '0;

    // Page crossing: both candidates skipped, two evaluation cycles
    seen.delete();
    cycle(1, 32'hCAFE0FC0, 0, 1, 0);
    check_eq("d3_busy1", busy_o, 1);
    cycle(0, '0, 0, 1, 0);
    check_eq("d3_busy2", busy_o, 1);
    cycle(0, '0, 0, 1, 0);
    check_eq("d3_idle", busy_o, 0);
    check_eq("d3_count", seen.size(), 0);

    // Backpressure: request held stable, trigger meanwhile dropped
    seen.delete();
    cycle(1, 32'hCAFE0000, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(i == 2, 32'hCAFE5000, 0, 0, 0);
      check_eq("d4_valid", pf_req_valid_o, 1);
      check_eq("d4_addr", pf_req_addr_o, 32'hCAFE0040);
      check_eq("d4_take", fifo_take_req_o[0], 0);
    end
    run_idle("d4_idle", 1, 20);
    repeat (3) cycle(0, '0, 0, 1, 0);
    check_eq("d4_count", seen.size(), 2);
    check_eq("d4_req1", seen_at(1), 32'hCAFE0080);
    drain();

    // Outstanding limit
    cycle(1, 32'hCAFE0000, 0, 1, 0);
    run_idle("d5_fill_a", 1, 20);
    cycle(1, 32'hCAFE0100, 0, 1, 0);
    run_idle("d5_fill_b", 1, 20);
    cycle(1, 32'hCAFE2000, 0, 1, 0);
    repeat (4) begin
      cycle(0, '0, 0, 1, 0);
      check_eq("d5_limit", pf_req_valid_o, 0);
    end
    cycle(0, '0, 0, 1, 1);
    check_eq("d5_release", pf_req_valid_o, 1);
    cycle(0, '0, 0, 1, 1);
    cycle(0, '0, 0, 0, 0);
    check_eq("d5_hs_rsp", pf_req_valid_o, 1);
    run_idle("d5_idle", 1, 20);
    drain();

    // Flush in ISSUE, without and with a coincident handshake
    cycle(1, 32'hCAFE3000, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    check_eq("d6_valid", pf_req_valid_o, 0);
    check_eq("d6_busy", busy_o, 0);
    check_eq("d6_take", fifo_take_req_o[0], 0);
    cycle(1, 32'hCAFE3000, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 1, 1, 0);
    check_eq("d6_hs_take", fifo_take_req_o[0], 0);
    cycle(0, '0, 0, 0, 0);
    drain();

    // Asynchronous reset mid-ISSUE
    cycle(1, 32'hCAFE4000, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("d7_valid", pf_req_valid_o, 0);
    check_eq("d7_busy", busy_o, 0);
    check_eq("d7_take", fifo_take_req_o, 0);
    check_eq("d7_addr", pf_req_addr_o, 0);
    check_eq("d7_cpu_req", fifo_cpu_req_o[0], 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random traffic; the FIFO snapshot only changes while the model is idle
    region = 32'hCAFE0000;
    for (int i = 0; i < 3000; i++) begin
      if (plan.size() == 0 && !m_req && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       region = 32'hFFFF_FF40;
          1:       region = 32'hCAFE_0F80;
          default: region = 32'hCAFE_0000 + 32'($urandom_range(0, 63)) * 32'd64;
        endcase
        for (int j = 0; j < QD; j++) begin
          fifo_data_cpu_i[j]   = (region & 32'hFFFF_FFC0) + 32'($urandom_range(1, 3)) * 32'd64;
          fifo_data_valid_i[j] = 1'($urandom_range(0, 1));
        end
        cycle(0, '0, 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      end else begin
        cycle($urandom_range(0, 3) == 0,
              region + 32'($urandom_range(0, 2) * 64 + $urandom_range(0, 63)),
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
